// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory controller:
//   dmem_state_e  - controller FSM state encoding (IDLE / WRITE_WAIT / READ_WAIT)
//   LAT_W         - width of the access latency counter
//   LFSR_SEED     - reset value of the optional latency LFSR
//   LFSR_TAPS     - Fibonacci tap mask for x^16 + x^14 + x^13 + x^11 + 1
//   lfsr_step()   - one shift of the 16-bit Fibonacci LFSR
// -----------------------------------------------------------------------------
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_WAIT = 2'd1,
    READ_WAIT  = 2'd2
  } dmem_state_e;

  localparam int          LAT_W     = 4;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Bits 15,13,12,10 correspond to taps 16,14,13,11.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl_if
// Cache <-> data-memory controller bus.
//   master modport : cache side (drives Start/Addr/Data, receives Finish/ReadData)
//   slave  modport : controller side
//
// Handshake: MemReadStart / MemWriteStart are levels held by the cache from the
// request until it returns to idle. The controller acts only on the rising
// edge of a Start, capturing address/data at that edge, and answers with a
// single-cycle MemReadFinish / MemWriteFinish pulse. A Start held high never
// produces a second request; the cache must drop and re-raise it.
// MemReadData is valid from the MemReadFinish cycle until the next read finish.
// -----------------------------------------------------------------------------
interface data_mem_ctrl_if;
  logic        MemReadStart;
  logic        MemWriteStart;
  logic [31:0] MemReadAddr;
  logic [31:0] MemWriteAddr;
  logic [31:0] MemWriteData;
  logic [31:0] MemReadData;
  logic        MemReadFinish;
  logic        MemWriteFinish;

  modport master (
    output MemReadStart, MemWriteStart, MemReadAddr, MemWriteAddr, MemWriteData,
    input  MemReadData, MemReadFinish, MemWriteFinish
  );

  modport slave (
    input  MemReadStart, MemWriteStart, MemReadAddr, MemWriteAddr, MemWriteData,
    output MemReadData, MemReadFinish, MemWriteFinish
  );
endinterface

// File: rtl/dmem_latency_gen.sv
// -----------------------------------------------------------------------------
// dmem_latency_gen
// Access latency counter. On load the counter takes the access latency; while
// run is high it counts down and done strobes in the last wait cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : dispatch of a new access (loads counter)
//   run        : controller is in a wait state
//   done       : terminal-count strobe (combinational, qualified by run)
// Macro DMEM_RANDOM_LATENCY_EN: when defined, each access latency is
// 1 + (lfsr[3:0] mod LATENCY) from a 16-bit Fibonacci LFSR stepped once per
// load; otherwise every access takes exactly LATENCY cycles.
// -----------------------------------------------------------------------------
module dmem_latency_gen
  import dmem_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic run,
  output logic done
);

  logic [LAT_W-1:0] cnt;
  logic [LAT_W-1:0] load_val;

`ifdef DMEM_RANDOM_LATENCY_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else if (load) begin
      lfsr <= lfsr_step(lfsr);
    end
  end

  // Result is always in 1..LATENCY, so a loaded counter is never zero.
  assign load_val = LAT_W'(1 + ({28'd0, lfsr[3:0]} % LATENCY));
`else
  assign load_val = LAT_W'(LATENCY);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (run && (cnt != '0)) begin
      cnt <= cnt - LAT_W'(1);
    end
  end

  assign done = run && (cnt == LAT_W'(1));

endmodule

// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
// Multi-cycle data-memory controller behind the write-back data cache. Models a
// word-addressed backing store with a fixed (or pseudo-random) access latency.
//   CLK       : clock, all state on rising edge
//   Reset     : asynchronous active-low reset
//   bus       : data_mem_ctrl_if.slave (Start/Addr/Data in, Finish/ReadData out)
//   dbg_state : current FSM state
// Parameters: ADDR_WIDTH (log2 words), LATENCY (1..15 cycles).
// Macro DMEM_RANDOM_LATENCY_EN selects pseudo-random latency in dmem_latency_gen.
// -----------------------------------------------------------------------------
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 4
) (
  input  logic           CLK,
  input  logic           Reset,
  data_mem_ctrl_if.slave bus,
  output dmem_state_e    dbg_state
);

  typedef logic [ADDR_WIDTH-1:0] widx_t;

  dmem_state_e state, state_next;

  logic        armed, rd_start_q, wr_start_q;
  logic        rd_rise, wr_rise;
  logic        rd_pend, wr_pend, rd_redo, wr_redo;
  widx_t       rd_addr_l, wr_addr_l, svc_addr;
  logic [31:0] wr_data_l, svc_data;
  logic        lat_load, lat_run, lat_done;
  logic        disp_wr, disp_rd, do_write, do_read;

  logic [31:0] mem [2**ADDR_WIDTH];

  // Byte-offset and high address bits are ignored (aliasing is intended).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.MemReadAddr[31:ADDR_WIDTH+2], bus.MemReadAddr[1:0],
                              bus.MemWriteAddr[31:ADDR_WIDTH+2], bus.MemWriteAddr[1:0]};

  // ---------------------------------------------------------------------------
  // Start edge detection. The first cycle after reset only loads the history,
  // so a Start already high across reset release is not taken as a request.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      armed      <= 1'b0;
      rd_start_q <= 1'b0;
      wr_start_q <= 1'b0;
    end else begin
      armed      <= 1'b1;
      rd_start_q <= bus.MemReadStart;
      wr_start_q <= bus.MemWriteStart;
    end
  end

  assign rd_rise = armed && bus.MemReadStart  && !rd_start_q;
  assign wr_rise = armed && bus.MemWriteStart && !wr_start_q;

  // ---------------------------------------------------------------------------
  // Request capture and pending flags. A new edge of the kind in service sets
  // *_redo so the flag survives the terminal cycle and the request is served
  // again; the service registers keep the in-flight address/data intact.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      wr_addr_l <= '0;
      wr_data_l <= '0;
      rd_addr_l <= '0;
      wr_pend   <= 1'b0;
      rd_pend   <= 1'b0;
      wr_redo   <= 1'b0;
      rd_redo   <= 1'b0;
    end else begin
      if (wr_rise) begin
        wr_addr_l <= bus.MemWriteAddr[ADDR_WIDTH+1:2];
        wr_data_l <= bus.MemWriteData;
      end
      if (rd_rise) begin
        rd_addr_l <= bus.MemReadAddr[ADDR_WIDTH+1:2];
      end

      if (wr_rise)                    wr_pend <= 1'b1;
      else if (do_write && !wr_redo)  wr_pend <= 1'b0;
      if (rd_rise)                    rd_pend <= 1'b1;
      else if (do_read && !rd_redo)   rd_pend <= 1'b0;

      if (do_write) wr_redo <= 1'b0;
      else if (wr_rise && ((state == WRITE_WAIT) || disp_wr)) wr_redo <= 1'b1;
      if (do_read) rd_redo <= 1'b0;
      else if (rd_rise && ((state == READ_WAIT) || disp_rd)) rd_redo <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      svc_addr <= '0;
      svc_data <= '0;
    end else if (disp_wr) begin
      svc_addr <= wr_addr_l;
      svc_data <= wr_data_l;
    end else if (disp_rd) begin
      svc_addr <= rd_addr_l;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        // Write wins so a write-back lands before the refill that follows it.
        if (wr_pend)      state_next = WRITE_WAIT;
        else if (rd_pend) state_next = READ_WAIT;
      end
      WRITE_WAIT: if (lat_done) state_next = IDLE;
      READ_WAIT:  if (lat_done) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    disp_wr  = 1'b0;
    disp_rd  = 1'b0;
    lat_load = 1'b0;
    lat_run  = 1'b0;
    do_write = 1'b0;
    do_read  = 1'b0;
    unique case (state)
      IDLE: begin
        disp_wr  = wr_pend;
        disp_rd  = !wr_pend && rd_pend;
        lat_load = wr_pend || rd_pend;
      end
      WRITE_WAIT: begin
        lat_run  = 1'b1;
        do_write = lat_done;
      end
      READ_WAIT: begin
        lat_run = 1'b1;
        do_read = lat_done;
      end
      default: ;
    endcase
  end

  assign dbg_state = state;

  dmem_latency_gen #(.LATENCY(LATENCY)) u_lat (
    .clk   (CLK),
    .rst_n (Reset),
    .load  (lat_load),
    .run   (lat_run),
    .done  (lat_done)
  );

  // ---------------------------------------------------------------------------
  // Backing store (not reset) and registered responses
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (do_write) mem[svc_addr] <= svc_data;
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      bus.MemWriteFinish <= 1'b0;
      bus.MemReadFinish  <= 1'b0;
      bus.MemReadData    <= '0;
    end else begin
      bus.MemWriteFinish <= do_write;
      bus.MemReadFinish  <= do_read;
      if (do_read) bus.MemReadData <= mem[svc_addr];
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_mem_ctrl
// Directed self-checking bench for data_mem_ctrl (ADDR_WIDTH=10, LATENCY=4).
// Latencies are counted in bench ticks: the request is driven just after an
// edge, so a finish LATENCY+1 edges after the sampling edge is seen on tick
// LATENCY+2. With DMEM_RANDOM_LATENCY_EN defined, latency checks become ranges.
// -----------------------------------------------------------------------------
module tb_data_mem_ctrl;
  import dmem_pkg::*;

  localparam int AW  = 10;
  localparam int LAT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  dmem_state_e dbg_state;

  always #5 clk = ~clk;

  data_mem_ctrl_if bus();

  data_mem_ctrl #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .CLK       (clk),
    .Reset     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_rdata = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_go(input logic [31:0] addr, input logic [31:0] data);
    bus.MemWriteAddr  = addr;
    bus.MemWriteData  = data;
    bus.MemWriteStart = 1'b1;
  endtask

  task automatic rd_go(input logic [31:0] addr, input logic [31:0] exp);
    bus.MemReadAddr  = addr;
    bus.MemReadStart = 1'b1;
    exp_q.push_back(exp);
  endtask

  task automatic release_starts();
    bus.MemReadStart  = 1'b0;
    bus.MemWriteStart = 1'b0;
  endtask

  task automatic no_finish(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tick();
      chk({tag, "_rfin"}, 32'(bus.MemReadFinish), 32'd0);
      chk({tag, "_wfin"}, 32'(bus.MemWriteFinish), 32'd0);
      chk({tag, "_rdata"}, bus.MemReadData, exp_rdata);
    end
  endtask

  // Waits for one finish pulse of the given kind; checks tick count, that the
  // other finish stays low, read data hold before the finish and read data at it.
  task automatic wait_fin(input bit is_rd, input int exp_n, input string tag);
    int   n = 0;
    logic fin, other;
    for (int i = 1; i <= 64; i++) begin
      tick();
      fin   = is_rd ? bus.MemReadFinish  : bus.MemWriteFinish;
      other = is_rd ? bus.MemWriteFinish : bus.MemReadFinish;
      chk({tag, "_other_fin"}, 32'(other), 32'd0);
      if (fin) begin
        n = i;
        break;
      end
      chk({tag, "_rdata_hold"}, bus.MemReadData, exp_rdata);
    end
    checks++;
    assert (n != 0) else begin
      errors++;
      $error("FAIL %s_timeout observed=no finish expected=finish within 64 cycles", tag);
    end
    if (n != 0) begin
`ifdef DMEM_RANDOM_LATENCY_EN
      checks++;
      assert (n >= exp_n - LAT + 1 && n <= exp_n) else begin
        errors++;
        $error("FAIL %s_lat observed=%0d expected=%0d..%0d", tag, n, exp_n - LAT + 1, exp_n);
      end
`else
      chk({tag, "_lat"}, 32'(n), 32'(exp_n));
`endif
      if (is_rd && exp_q.size() != 0) begin
        exp_rdata = exp_q.pop_front();
        chk({tag, "_data"}, bus.MemReadData, exp_rdata);
      end
    end
  endtask

  task automatic pulse_low(input string tag);
    tick();
    chk({tag, "_rfin_low"}, 32'(bus.MemReadFinish), 32'd0);
    chk({tag, "_wfin_low"}, 32'(bus.MemWriteFinish), 32'd0);
  endtask

  task automatic full_write(input logic [31:0] addr, input logic [31:0] data, input string tag);
    wr_go(addr, data);
    wait_fin(1'b0, LAT + 2, tag);
    pulse_low(tag);
    release_starts();
    tick();
  endtask

  task automatic full_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    rd_go(addr, exp);
    wait_fin(1'b1, LAT + 2, tag);
    pulse_low(tag);
    release_starts();
    tick();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=bench completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n             = 1'b0;
    bus.MemReadStart  = 1'b1;
    bus.MemWriteStart = 1'b1;
    bus.MemReadAddr   = 32'h0;
    bus.MemWriteAddr  = 32'h0;
    bus.MemWriteData  = 32'h0;

    // Reset with both Starts high: outputs quiet, FSM idle.
    tick(); tick(); tick();
    chk("rst_rfin",  32'(bus.MemReadFinish), 32'd0);
    chk("rst_wfin",  32'(bus.MemWriteFinish), 32'd0);
    chk("rst_rdata", bus.MemReadData, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));

    // Release with Starts still held: no edge, so no request.
    rst_n = 1'b1;
    no_finish("held_start", 12);
    chk("held_state", 32'(dbg_state), 32'(IDLE));
    release_starts();
    tick(); tick();

    // Basic write then read-back of the same word.
    full_write(32'h0000_0040, 32'hDEADBEEF, "wr40");
    full_read (32'h0000_0040, 32'hDEADBEEF, "rd40");
    no_finish("rd40_hold", 5);

    // Write-back followed by refill: read edge one cycle after write finish.
    full_write(32'h0000_0200, 32'h0BADF00D, "wr200");
    wr_go(32'h0000_0100, 32'h11112222);
    wait_fin(1'b0, LAT + 2, "wb_wr");
    rd_go(32'h0000_0200, 32'h0BADF00D);
    wait_fin(1'b1, LAT + 2, "wb_rd");
    pulse_low("wb");
    release_starts();
    tick();
    full_read(32'h0000_0100, 32'h11112222, "rd100");

    // Simultaneous edges on the same word: write first, read sees new data.
    wr_go(32'h0000_0008, 32'h12345678);
    rd_go(32'h0000_0008, 32'h12345678);
    wait_fin(1'b0, LAT + 2, "sim_wr");
    wait_fin(1'b1, LAT + 1, "sim_rd");
    pulse_low("sim");
    release_starts();
    tick();

    // Aliasing: 0x1004 and 0x0004 share word index 1 with ADDR_WIDTH=10.
    full_write(32'h0000_1004, 32'h5A5A5A5A, "alias_wr");
    full_read (32'h0000_0004, 32'h5A5A5A5A, "alias_rd");

`ifndef DMEM_RANDOM_LATENCY_EN
    // Second write edge while the first write is in service: both performed.
    wr_go(32'h0000_0020, 32'hA1A1A1A1);
    tick(); tick();
    chk("redo_state", 32'(dbg_state), 32'(WRITE_WAIT));
    bus.MemWriteStart = 1'b0;
    tick();
    wr_go(32'h0000_0024, 32'hB2B2B2B2);
    wait_fin(1'b0, 3, "redo_wr1");
    wait_fin(1'b0, LAT + 1, "redo_wr2");
    pulse_low("redo");
    release_starts();
    tick();
    full_read(32'h0000_0020, 32'hA1A1A1A1, "redo_rd1");
    full_read(32'h0000_0024, 32'hB2B2B2B2, "redo_rd2");
`endif

    // Reset during WRITE_WAIT: aborted, array keeps old word.
    wr_go(32'h0000_0040, 32'h77777777);
    tick(); tick();
    chk("abort_wr_state", 32'(dbg_state), 32'(WRITE_WAIT));
    rst_n = 1'b0;
    #1;
    chk("abort_wr_idle", 32'(dbg_state), 32'(IDLE));
    chk("abort_wr_fin",  32'(bus.MemWriteFinish), 32'd0);
    exp_rdata = 32'd0;
    chk("abort_wr_rdata", bus.MemReadData, exp_rdata);
    release_starts();
    tick(); tick();
    rst_n = 1'b1;
    no_finish("abort_wr_quiet", 8);
    full_read(32'h0000_0040, 32'hDEADBEEF, "abort_wr_rb");

    // Reset during READ_WAIT: no finish, read data back to zero.
    rd_go(32'h0000_0040, 32'hDEADBEEF);
    tick(); tick();
    chk("abort_rd_state", 32'(dbg_state), 32'(READ_WAIT));
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_rdata = 32'd0;
    chk("abort_rd_rdata", bus.MemReadData, exp_rdata);
    chk("abort_rd_fin",   32'(bus.MemReadFinish), 32'd0);
    release_starts();
    tick(); tick();
    rst_n = 1'b1;
    no_finish("abort_rd_quiet", 8);

`ifdef DMEM_RANDOM_LATENCY_EN
    // Many reads: each completes with latency within 1..LATENCY.
    for (int i = 0; i < 100; i++) begin
      full_read(32'h0000_0040, 32'hDEADBEEF, "rand_rd");
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
